// File: rtl/gray_step_sequencer_if.sv
// rtl/gray_step_sequencer_if.sv - command channel of the Gray step sequencer
interface gray_step_sequencer_if #(
  parameter int DATA_WID = 4
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [DATA_WID:0]   cmd_len;
  logic                cmd_clr;

  // Control side: offers commands, observes readiness
  modport master (
    output cmd_valid,
    output cmd_len,
    output cmd_clr,
    input  cmd_ready
  );

  // Sequencer side: consumes commands, reports readiness
  modport slave (
    input  cmd_valid,
    input  cmd_len,
    input  cmd_clr,
    output cmd_ready
  );
endinterface

// File: rtl/gray_step_sequencer.sv
// rtl/gray_step_sequencer.sv - command-driven Gray-code step counter
module gray_step_sequencer #(
  parameter int DATA_WID = 4
) (
  input  logic                  clk,
  input  logic                  n_reset,
  gray_step_sequencer_if.slave  cmd,
  input  logic                  pause,
  input  logic                  abort,
  output logic [DATA_WID-1:0]   Count,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_WID-1:0] bin;
  logic [DATA_WID-1:0] bin_inc;
  logic [DATA_WID:0]   remaining;
  logic                ready_q;

  function automatic logic [DATA_WID-1:0] to_gray(input logic [DATA_WID-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Next binary position; wraps naturally at 2**DATA_WID
  assign bin_inc       = bin + 1'b1;
  assign cmd.cmd_ready = ready_q;

  // Sequencer FSM; every output is registered from the next-state decision,
  // and ready stays low until the first edge after reset release
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      bin       <= '0;
      remaining <= '0;
      Count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          // Clear applies before a same-edge accept, so the run starts at 0
          if (cmd.cmd_clr) begin
            bin   <= '0;
            Count <= '0;
          end
          if (cmd.cmd_valid && ready_q) begin
            remaining <= cmd.cmd_len;
            ready_q   <= 1'b0;
            if (cmd.cmd_len != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            aborted   <= 1'b1;
            remaining <= '0;
            ready_q   <= 1'b1;
          end else if (!pause) begin
            bin       <= bin_inc;
            Count     <= to_gray(bin_inc);
            remaining <= remaining - 1'b1;
            if (remaining == {{DATA_WID{1'b0}}, 1'b1}) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
